// File: rtl/baud_pkg.sv
// baud_pkg: shared UART baud definitions.
// Holds the baud-code encoding, the supported rate list and the rounded
// divisor function used by the timing generator, TX/RX and register blocks.
package baud_pkg;

   // 4-bit baud codes as written by software into the control register.
   typedef enum logic [3:0] {
      BAUD_300    = 4'd0,
      BAUD_1200   = 4'd1,
      BAUD_2400   = 4'd2,
      BAUD_4800   = 4'd3,
      BAUD_9600   = 4'd4,
      BAUD_19200  = 4'd5,
      BAUD_38400  = 4'd6,
      BAUD_57600  = 4'd7,
      BAUD_115200 = 4'd8,
      BAUD_230400 = 4'd9,
      BAUD_460800 = 4'd10,
      BAUD_921600 = 4'd11
   } baud_code_e;

   localparam int unsigned BAUD_NUM_CODES    = 12;
   localparam logic [3:0]  BAUD_CODE_DEFAULT = BAUD_300;
   localparam int unsigned BAUD_MIN_DIV      = 2;

   // Rate list; unused codes fall back to the slowest rate.
   function automatic int unsigned baud_rate(input logic [3:0] code);
      case (code)
         BAUD_300:    return 300;
         BAUD_1200:   return 1200;
         BAUD_2400:   return 2400;
         BAUD_4800:   return 4800;
         BAUD_9600:   return 9600;
         BAUD_19200:  return 19200;
         BAUD_38400:  return 38400;
         BAUD_57600:  return 57600;
         BAUD_115200: return 115200;
         BAUD_230400: return 230400;
         BAUD_460800: return 460800;
         BAUD_921600: return 921600;
         default:     return 300;
      endcase
   endfunction

   // Clock cycles per bit for a code, rounded to nearest.
   function automatic longint unsigned baud_div(input longint unsigned clk_hz,
                                                input logic [3:0]       code);
      longint unsigned rate;
      rate = 64'(baud_rate(code));
      return (clk_hz + rate / 2) / rate;
   endfunction

endpackage

// File: rtl/baud_tick_gen_if.sv
// baud_tick_gen_if: control/strobe bundle between the UART register block
// (master) and the baud timing generator (slave).
interface baud_tick_gen_if #(
   parameter int unsigned CNT_W = 20
);
   logic             enable;
   logic             restart;
   logic [3:0]       baud_sel;
   logic [CNT_W-1:0] custom_div;
   logic             use_custom;
   logic             bit_tick;
   logic             half_tick;
   logic [CNT_W-1:0] k_active;
   logic             div_err;

   modport master (
      output enable, restart, baud_sel, custom_div, use_custom,
      input  bit_tick, half_tick, k_active, div_err
   );

   modport slave (
      input  enable, restart, baud_sel, custom_div, use_custom,
      output bit_tick, half_tick, k_active, div_err
   );
endinterface

// File: rtl/baud_div_table.sv
// baud_div_table: combinational baud code -> divisor ROM.
// Every entry is a constant computed from CLK_HZ at elaboration.
module baud_div_table
   import baud_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned CNT_W  = 20
) (
   input  logic [3:0]       code,
   output logic [CNT_W-1:0] div
);

   logic [CNT_W-1:0] rom [16];

   for (genvar i = 0; i < 16; i++) begin : g_rom
      localparam logic [CNT_W-1:0] K = CNT_W'(baud_div(64'(CLK_HZ), 4'(i)));
      assign rom[i] = K;
   end

   // ROM lookup
   always_comb begin
      div = rom[code];
   end

endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: UART bit-period and mid-bit strobe generator.
// Optional feature macro: BAUD_CUSTOM_EN enables the runtime custom divisor
// (custom_div/use_custom) and the sticky div_err clamp flag. Without it the
// custom inputs are ignored and div_err stays 0.
module baud_tick_gen
   import baud_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned CNT_W  = 20
) (
   input logic             clk,
   input logic             reset,
   baud_tick_gen_if.slave  bus
);

   localparam logic [CNT_W-1:0] K_RESET = CNT_W'(baud_div(64'(CLK_HZ), BAUD_CODE_DEFAULT));
   localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(BAUD_MIN_DIV);

   logic [CNT_W-1:0] table_div;
   logic [CNT_W-1:0] req_div;
   logic [CNT_W-1:0] half_div;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] k_active;
   logic             run;
   logic             at_wrap;
   logic             at_half;
   logic             load;
   logic             bit_tick_q;
   logic             half_tick_q;
   logic             div_err_q;

   baud_div_table #(
      .CLK_HZ (CLK_HZ),
      .CNT_W  (CNT_W)
   ) u_div_table (
      .code (bus.baud_sel),
      .div  (table_div)
   );

`ifdef BAUD_CUSTOM_EN
   logic clamp_hit;

   // Requested divisor: custom value (clamped to a minimum of 2) or table entry
   always_comb begin
      req_div   = table_div;
      clamp_hit = 1'b0;
      if (bus.use_custom) begin
         if (bus.custom_div < MIN_DIV) begin
            req_div   = MIN_DIV;
            clamp_hit = 1'b1;
         end else begin
            req_div = bus.custom_div;
         end
      end
   end

   // Sticky clamp flag, cleared only by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_err_q <= 1'b0;
      end else if (clamp_hit) begin
         div_err_q <= 1'b1;
      end
   end
`else
   logic unused_custom;

   // Table-only divisor; custom inputs are deliberately ignored
   always_comb begin
      req_div       = table_div;
      div_err_q     = 1'b0;
      unused_custom = ^{bus.custom_div, bus.use_custom, MIN_DIV};
   end
`endif

   // Phase decode; load points are exactly the edges where cnt returns to 0
   always_comb begin
      half_div = k_active >> 1;
      run      = bus.enable & ~bus.restart;
      at_wrap  = (cnt == k_active - 1'b1);
      at_half  = (cnt == half_div - 1'b1);
      load     = ~run | at_wrap;
   end

   // Bit-phase counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (!run || at_wrap) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Active divisor, only swapped at a bit boundary so a period is never cut
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k_active <= K_RESET;
      end else if (load) begin
         k_active <= req_div;
      end
   end

   // Registered one-cycle strobes; restart suppresses a coincident wrap
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_tick_q  <= 1'b0;
         half_tick_q <= 1'b0;
      end else begin
         bit_tick_q  <= run & at_wrap;
         half_tick_q <= run & at_half;
      end
   end

   assign bus.bit_tick  = bit_tick_q;
   assign bus.half_tick = half_tick_q;
   assign bus.k_active  = k_active;
   assign bus.div_err   = div_err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: directed + randomized bench for baud_tick_gen against a
// bit-period reference model. Honours BAUD_CUSTOM_EN like the design.
module tb_baud_tick_gen;

   localparam int unsigned CLK_HZ = 4_000_000;
   localparam int unsigned CNT_W  = 20;
`ifdef BAUD_CUSTOM_EN
   localparam bit CUSTOM_EN = 1'b1;
`else
   localparam bit CUSTOM_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;

   baud_tick_gen_if #(.CNT_W(CNT_W)) bus ();

   baud_tick_gen #(
      .CLK_HZ (CLK_HZ),
      .CNT_W  (CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: edges elapsed in the current bit period and its length
   int unsigned m_k;
   int unsigned m_phase;
   bit          m_bit;
   bit          m_half;
   bit          m_err;

   function automatic int unsigned rate_of(input int unsigned code);
      int unsigned rates [12] = '{300, 1200, 2400, 4800, 9600, 19200, 38400,
                                  57600, 115200, 230400, 460800, 921600};
      return (code < 12) ? rates[code] : 300;
   endfunction

   function automatic int unsigned code_div(input int unsigned code);
      int unsigned r;
      r = rate_of(code);
      return (CLK_HZ + r / 2) / r;
   endfunction

   function automatic int unsigned requested();
      int unsigned c;
      c = int'(bus.custom_div);
      if (CUSTOM_EN && bus.use_custom === 1'b1)
         return (c < 2) ? 2 : c;
      return code_div(int'(bus.baud_sel));
   endfunction

   task automatic model_reset();
      m_k     = code_div(0);
      m_phase = 0;
      m_bit   = 1'b0;
      m_half  = 1'b0;
      m_err   = 1'b0;
   endtask

   task automatic model_edge();
      int unsigned req;
      req = requested();
      if (reset) begin
         model_reset();
         return;
      end
      if (CUSTOM_EN && bus.use_custom && int'(bus.custom_div) < 2) m_err = 1'b1;
      m_bit  = 1'b0;
      m_half = 1'b0;
      if (!bus.enable || bus.restart) begin
         m_phase = 0;
         m_k     = req;
      end else begin
         m_phase++;
         if (m_phase == m_k / 2) m_half = 1'b1;
         if (m_phase == m_k) begin
            m_bit   = 1'b1;
            m_phase = 0;
            m_k     = req;
         end
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("bit_tick",  64'(bus.bit_tick),  64'(m_bit));
      check("half_tick", 64'(bus.half_tick), 64'(m_half));
      check("k_active",  64'(bus.k_active),  64'(m_k));
      check("div_err",   64'(bus.div_err),   64'(m_err));
   endtask

   // One clock edge: advance the model, then compare away from the edge
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic edges_to_bit(output int n, input int limit);
      n = 0;
      do begin
         step();
         n++;
      end while (bus.bit_tick !== 1'b1 && n < limit);
   endtask

   task automatic first_ticks(output int nh, output int nb, input int limit);
      int n;
      n  = 0;
      nh = -1;
      nb = -1;
      while (nb < 0 && n < limit) begin
         step();
         n++;
         if (bus.half_tick === 1'b1 && nh < 0) nh = n;
         if (bus.bit_tick === 1'b1) nb = n;
      end
   endtask

   initial begin
      int n, nh, nb, guard;
      int unsigned exp_k;

      bus.enable     = 1'b0;
      bus.restart    = 1'b0;
      bus.baud_sel   = 4'd0;
      bus.custom_div = '0;
      bus.use_custom = 1'b0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_all();
      check("reset_k_active", 64'(bus.k_active), 64'(13333));
      reset = 1'b0;

      // 115200: first half/bit latency from enable, then steady periods
      bus.baud_sel = 4'd8;
      step();
      bus.enable = 1'b1;
      first_ticks(nh, nb, 200);
      check("first_half_115200", 64'(nh), 64'(17));
      check("first_bit_115200",  64'(nb), 64'(35));
      check("k_115200", 64'(bus.k_active), 64'(35));
      repeat (3 * 35) step();

      // Mid-bit request change must not alter the current period
      repeat (10) step();
      bus.baud_sel = 4'd7;
      edges_to_bit(n, 200);
      check("period_during_switch", 64'(n), 64'(25));
      check("k_after_wrap", 64'(bus.k_active), 64'(69));

      // Fastest code: steady periods of 4
      bus.baud_sel = 4'd11;
      edges_to_bit(n, 200);
      check("period_57600", 64'(n), 64'(69));
      for (int i = 0; i < 20; i++) begin
         edges_to_bit(n, 20);
         check("period_921600", 64'(n), 64'(4));
      end
      bus.restart = 1'b1;
      step();
      bus.restart = 1'b0;
      first_ticks(nh, nb, 20);
      check("first_half_921600", 64'(nh), 64'(2));
      check("first_bit_921600",  64'(nb), 64'(4));

      // Restart at a random mid-bit point
      bus.baud_sel = 4'd8;
      edges_to_bit(n, 20);
      repeat ($urandom_range(3, 30)) step();
      bus.restart = 1'b1;
      step();
      bus.restart = 1'b0;
      first_ticks(nh, nb, 200);
      check("restart_half", 64'(nh), 64'(17));
      check("restart_bit",  64'(nb), 64'(35));

      // Restart coincident with wrap, with a new code requested
      guard = 0;
      while (m_phase != m_k - 1 && guard < 100) begin
         step();
         guard++;
      end
      bus.restart  = 1'b1;
      bus.baud_sel = 4'd9;
      step();
      check("restart_on_wrap_bit", 64'(bus.bit_tick), 64'(0));
      check("restart_on_wrap_k",   64'(bus.k_active), 64'(17));
      bus.restart = 1'b0;
      first_ticks(nh, nb, 100);
      check("wrap_restart_half", 64'(nh), 64'(8));
      check("wrap_restart_bit",  64'(nb), 64'(17));

      // Randomized mix of code changes, restarts, enable drops, custom divisors
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0: bus.baud_sel = 4'($urandom_range(5, 11));
            1: begin
               bus.restart = 1'b1;
               step();
               bus.restart = 1'b0;
            end
            2: begin
               bus.enable = 1'b0;
               repeat ($urandom_range(1, 3)) step();
               bus.enable = 1'b1;
            end
            3: begin
               bus.use_custom = ($urandom_range(0, 3) == 0);
               bus.custom_div = CNT_W'($urandom_range(0, 40));
            end
            default: ;
         endcase
         repeat ($urandom_range(1, 60)) step();
      end
      bus.use_custom = 1'b0;
      bus.custom_div = '0;
      bus.enable     = 1'b1;
      bus.restart    = 1'b0;

      // Custom divisor below minimum: clamped to 2 and flagged
      bus.baud_sel   = 4'd9;
      bus.use_custom = 1'b1;
      bus.custom_div = CNT_W'(1);
      bus.restart    = 1'b1;
      step();
      bus.restart = 1'b0;
      exp_k = CUSTOM_EN ? 2 : code_div(9);
      check("custom_k_active", 64'(bus.k_active), 64'(exp_k));
      for (int i = 0; i < 4; i++) begin
         edges_to_bit(n, 40);
         check("custom_period", 64'(n), 64'(exp_k));
      end
      check("custom_div_err", 64'(bus.div_err), 64'(CUSTOM_EN));
      bus.use_custom = 1'b0;
      repeat (30) step();
      check("div_err_sticky", 64'(bus.div_err), 64'(CUSTOM_EN));

      // Reset asserted mid-bit at 300 baud, right after a half_tick
      bus.baud_sel = 4'd0;
      bus.enable   = 1'b0;
      step();
      bus.enable = 1'b1;
      first_ticks(nh, nb, 7000);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      check("rst_half_tick", 64'(bus.half_tick), 64'(0));
      check("rst_k_active",  64'(bus.k_active),  64'(13333));
      check("rst_div_err",   64'(bus.div_err),   64'(0));
      repeat (2) step();
      reset = 1'b0;
      first_ticks(nh, nb, 14000);
      check("post_reset_half", 64'(nh), 64'(6666));
      check("post_reset_bit",  64'(nb), 64'(13333));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised UART baud-rate timing generator: turns a 4-bit baud code (or a runtime custom divisor) into registered one-cycle `bit_tick` and mid-bit `half_tick` strobes for any system clock frequency. It sits between the UART control registers and the TX/RX shift engines. It replaces fixed 100 MHz divisor lookups with divisors computed from `CLK_HZ`, glitch-free divisor changes at bit boundaries, and a phase-restart input that RX uses on start-bit detection.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency in Hz
- `CNT_W`, 20, counter/divisor width; must hold the 300-baud divisor (`CLK_HZ`/300)
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  run counter; low holds counter at 0 and suppresses ticks
- `restart`  in  1  synchronous phase realign; counter to 0 this edge
- `baud_sel`  in  4  baud code: 0000=300, 0001=1200, 0010=2400, 0011=4800, 0100=9600, 0101=19200, 0110=38400, 0111=57600, 1000=115200, 1001=230400, 1010=460800, 1011=921600, 1100–1111=300
- `custom_div`  in  CNT_W  runtime divisor (custom mode only)
- `use_custom`  in  1  select `custom_div` instead of `baud_sel` (custom mode only)
- `bit_tick`  out  1  one-cycle strobe once per bit period
- `half_tick`  out  1  one-cycle strobe at mid-bit
- `k_active`  out  CNT_W  divisor currently in use
- `div_err`  out  1  sticky: a custom divisor < 2 was clamped

## Operation
- Divisor for code c: k = (CLK_HZ + baud/2) / baud, integer, round-to-nearest; at 100 MHz: 333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736, 868, 434, 217, 109.
- Half divisor h = floor(k_active/2).
- Counter `cnt` (CNT_W bits): restart or enable low → 0; else if cnt == k_active−1 → 0, otherwise +1.
- `bit_tick` registered high for the cycle after the edge on which cnt wraps (k_active−1 → 0).
- `half_tick` registered high for the cycle after the edge on which cnt == h−1 increments.
- Requested divisor (`baud_sel`/custom) is recomputed combinationally each cycle and loaded into `k_active` only: on the wrap edge, on a restart edge, or on any edge with enable low. A mid-bit request change never alters the current period.
- Restart coincident with wrap: restart wins; cnt → 0, no `bit_tick`, new divisor loaded.
- Restart with enable low: no additional effect.
- A divisor load that leaves cnt ≥ new k_active−1 cannot occur, because loads coincide with cnt → 0.

## Timing
- Reset: cnt=0, `bit_tick`=0, `half_tick`=0, `k_active`=divisor of code 0000 (333333 at 100 MHz), `div_err`=0.
- From the restart edge (or the first enabled edge after enable rises), the first `half_tick` is high after h edges and the first `bit_tick` after k_active edges. Both then repeat every k_active edges.
- All outputs are registered. No combinational path runs from inputs to outputs.
- Reset asserted mid-bit: all state returns to reset values immediately. Counting resumes on the first edge after deassertion if enabled.

## Configuration
- `BAUD_CUSTOM_EN` defined: `custom_div`/`use_custom` are active. When `use_custom`=1 the requested divisor is `custom_div`. A value < 2 is clamped to 2 and sets `div_err` (cleared only by reset).
- Not defined: `custom_div`/`use_custom` are present but ignored, `div_err` is tied 0, and only table divisors are used.

## Structure
- Shared package `baud_pkg`: baud-code localparams, the baud-rate list, and a constant function `baud_div(clk_hz, code)` returning the rounded divisor. TX/RX and register blocks reuse these.
- One sub-module is natural: `baud_div_table`, a combinational code→divisor ROM built from `baud_pkg` at elaboration. The counter/strobe logic stays in `baud_tick_gen`.

## Test plan
- CLK_HZ=100e6, baud_sel=1000, enable=1 after reset → `half_tick` 434 edges after enable, then `bit_tick` every 868 edges; `k_active`=868.
- baud_sel=1011 → period 109, first `half_tick` at 54 edges; 20 consecutive periods measured exactly 109.
- Running at 1000, switch to 0111 at cnt=300 → current period still 868; next periods 1736; `k_active` changes on the wrap edge.
- Restart at cnt=500 (k=868) → no tick at old phase; `half_tick` 434 edges and `bit_tick` 868 edges after restart; restart on a wrap edge → no `bit_tick` that cycle.
- BAUD_CUSTOM_EN, use_custom=1, custom_div=1 → `k_active`=2, `bit_tick` every 2 edges, `div_err`=1 held until reset.
- Reset asserted mid-bit at 300 baud → outputs 0 and `k_active`=333333 immediately; after release, first `bit_tick` 333333 edges later.
